// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART blocks.
// Common to receiver and the future transmitter; holds the FSM encoding and divider math.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic RX_IDLE_LEVEL = 1'b1;

    // Clock cycles per oversample tick; never below 1 so the tick generator stays legal.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        int d;
        d = clk_freq / (baud * os);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick every DIV clocks.
// With DIV=1 the tick is permanently high.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit sampling, false-start and framing detection.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter logic PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output uart_state_e          dbg_state
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta, rxs;
    uart_state_e          state, state_next;
    logic [OSW-1:0]       os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shifter;
    logic                 at_point, start_ok, shift_en, stop_en;
    logic                 par_bad;
    logic                 accept;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= RX_IDLE_LEVEL;
            rxs     <= RX_IDLE_LEVEL;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (tick && rxs != RX_IDLE_LEVEL) state_next = START;
            START:  if (at_point) state_next = start_ok ? DATA : IDLE;
`ifdef UART_RX_PARITY_EN
            DATA:   if (at_point && bit_cnt == BIT_LAST) state_next = PARITY;
`else
            DATA:   if (at_point && bit_cnt == BIT_LAST) state_next = STOP;
`endif
            PARITY: if (at_point) state_next = STOP;
            STOP:   if (at_point) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Start is checked half a bit in; every later bit is checked one full bit after that.
    always_comb begin
        at_point = 1'b0;
        start_ok = 1'b0;
        shift_en = 1'b0;
        stop_en  = 1'b0;
        if (tick) begin
            case (state)
                START: begin
                    at_point = (os_cnt == OS_HALF);
                    start_ok = at_point && (rxs != RX_IDLE_LEVEL);
                end
                DATA: begin
                    at_point = (os_cnt == OS_LAST);
                    shift_en = at_point;
                end
                PARITY: at_point = (os_cnt == OS_LAST);
                STOP: begin
                    at_point = (os_cnt == OS_LAST);
                    stop_en  = at_point;
                end
                default: at_point = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            shifter <= '0;
        end else if (tick) begin
            if (state == IDLE || at_point) os_cnt <= '0;
            else                           os_cnt <= os_cnt + OSW'(1);
            if (start_ok) bit_cnt <= '0;
            if (shift_en) begin
                shifter <= {rxs, shifter[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_en;
    assign par_en = at_point && (state == PARITY);

    always_ff @(posedge clk) begin
        if (rst)           par_bad <= 1'b0;
        else if (start_ok) par_bad <= 1'b0;
        else if (par_en)   par_bad <= rxs ^ (^shifter) ^ PARITY_ODD;
    end
`else
    assign par_bad = 1'b0;
`endif

    // Handshake: a byte transfers on any clk where rx_valid && rx_ready; rx_data is held
    // stable while rx_valid is high, and rx_valid drops the clk after the transfer.
    assign accept = rx_valid && rx_ready;

    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            parity_err_q <= 1'b0;
            if (accept) rx_valid <= 1'b0;
            if (stop_en) begin
                frame_err    <= (rxs != RX_IDLE_LEVEL);
                parity_err_q <= par_bad;
                if (rxs == RX_IDLE_LEVEL && !par_bad) begin
                    // A byte consumed this same clk frees the slot for the new one.
                    if (!rx_valid || accept) begin
                        rx_data  <= shifter;
                        rx_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at 16 clk per bit (DIV=1); parity test when UART_RX_PARITY_EN.
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_CLKS = 16;
`else
    localparam int PAR_CLKS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, overrun, parity_err;
    uart_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_rise = 0, valid_hi = 0, fe_hi = 0, ov_hi = 0, pe_hi = 0;
    int last_rise_cyc = 0, edge_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];

    uart_rx_os #(
        .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16), .DATA_BITS(8)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Pulse counters and accepted-byte capture, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rx_valid && !prev_valid) begin
                valid_rise++;
                last_rise_cyc = cyc;
            end
            if (rx_valid)   valid_hi++;
            if (frame_err)  fe_hi++;
            if (overrun)    ov_hi++;
            if (parity_err) pe_hi++;
            if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
        end
        prev_valid = rx_valid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        edge_cyc = cyc;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        wait_clks(BIT_CLKS);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_b;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clks(4);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got=%b exp=000", {frame_err, overrun, parity_err}); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        rst = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_basic_a5;
        int vr, vh, fe, lat;
        vr = valid_rise; vh = valid_hi; fe = fe_hi;
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(20);
        lat = last_rise_cyc - edge_cyc;
        checks++; if (valid_rise - vr !== 1) begin errors++; $display("FAIL a5_rises got=%0d exp=1", valid_rise - vr); end
        checks++; if (valid_hi - vh !== 1) begin errors++; $display("FAIL a5_valid_width got=%0d exp=1", valid_hi - vh); end
        checks++; if (fe_hi - fe !== 0) begin errors++; $display("FAIL a5_frame_err got=%0d exp=0", fe_hi - fe); end
        checks++; if (lat < 150 + PAR_CLKS || lat > 158 + PAR_CLKS) begin errors++; $display("FAIL a5_latency got=%0d exp=%0d..%0d", lat, 150 + PAR_CLKS, 158 + PAR_CLKS); end
        checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL a5_count got=%0d exp=1", rcv_q.size()); end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = rcv_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL a5_data got=%h exp=%h", g, e); end
        end
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_false_start;
        int vr, fe, ov;
        vr = valid_rise; fe = fe_hi; ov = ov_hi;
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(40);
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL glitch_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if ({valid_rise - vr, fe_hi - fe, ov_hi - ov} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL glitch_pulses got=%0d/%0d/%0d exp=0/0/0", valid_rise - vr, fe_hi - fe, ov_hi - ov);
        end
    endtask

    task automatic test_frame_err;
        int vr, fe;
        vr = valid_rise; fe = fe_hi;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(40);
        checks++; if (fe_hi - fe !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", fe_hi - fe); end
        checks++; if (valid_rise - vr !== 0) begin errors++; $display("FAIL ferr_valid got=%0d exp=0", valid_rise - vr); end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL ferr_state got=%0d exp=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_overrun;
        int ov, vr;
        ov = ov_hi; vr = valid_rise;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clks(20);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
        checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got=%h exp=11", rx_data); end
        checks++; if (ov_hi - ov !== 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ov_hi - ov); end
        checks++; if (valid_rise - vr !== 1) begin errors++; $display("FAIL ovr_rises got=%0d exp=1", valid_rise - vr); end
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got=%b exp=0", rx_valid); end
        checks++; if (rcv_q.size() !== 1 || rcv_q[0] !== 8'h11) begin errors++; $display("FAIL ovr_consumed got_n=%0d exp=1 byte 11", rcv_q.size()); end
        rcv_q.delete();
        wait_clks(4);
    endtask

    task automatic test_reset_mid_frame;
        int vr, fe;
        rx_ready = 1'b1;
        rx = 1'b0;
        wait_clks(BIT_CLKS * 4 + 8);
        rst = 1'b1;
        rx = 1'b1;
        wait_clks(3);
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, IDLE); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", rx_valid); end
        rst = 1'b0;
        vr = valid_rise; fe = fe_hi;
        wait_clks(40);
        checks++; if (valid_rise - vr !== 0 || fe_hi - fe !== 0) begin errors++; $display("FAIL midrst_abort got=%0d/%0d exp=0/0", valid_rise - vr, fe_hi - fe); end
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clks(20);
        checks++; if (rcv_q.size() !== 1) begin errors++; $display("FAIL midrst_count got=%0d exp=1", rcv_q.size()); end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = rcv_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL midrst_data got=%h exp=%h", g, e); end
        end
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat [4];
        pat[0] = 8'h96; pat[1] = 8'h69; pat[2] = 8'hFF; pat[3] = 8'h00;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(pat[i]);
            send_frame(pat[i], 1'b1, 1'b0);
        end
        wait_clks(20);
        checks++; if (rcv_q.size() !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", rcv_q.size()); end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g, e;
            g = rcv_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_data got=%h exp=%h", g, e); end
        end
        rcv_q.delete(); exp_q.delete();
    endtask

    task automatic test_stuck_low;
        int vr, fe;
        vr = valid_rise; fe = fe_hi;
        rx = 1'b0;
        wait_clks(480);
        checks++; if (fe_hi - fe !== 3) begin errors++; $display("FAIL stuck_ferr got=%0d exp=3", fe_hi - fe); end
        checks++; if (valid_rise - vr !== 0) begin errors++; $display("FAIL stuck_valid got=%0d exp=0", valid_rise - vr); end
        rx = 1'b1;
        wait_clks(200);
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL stuck_recover got=%0d exp=%0d", dbg_state, IDLE); end
        rx_ready = 1'b1;
        wait_clks(2);
        rcv_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int pe, vr;
        pe = pe_hi; vr = valid_rise;
        rx_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(20);
        checks++; if (pe_hi - pe !== 1) begin errors++; $display("FAIL par_err_pulse got=%0d exp=1", pe_hi - pe); end
        checks++; if (valid_rise - vr !== 0) begin errors++; $display("FAIL par_err_valid got=%0d exp=0", valid_rise - vr); end
        pe = pe_hi;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(20);
        checks++; if (pe_hi - pe !== 0) begin errors++; $display("FAIL par_ok_pulse got=%0d exp=0", pe_hi - pe); end
        checks++; if (rcv_q.size() !== 1 || rcv_q[0] !== 8'h07) begin errors++; $display("FAIL par_ok_data got_n=%0d exp=1 byte 07", rcv_q.size()); end
        rcv_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_a5();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_stuck_low();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
